// File: rtl/rggen_register_access_controller_if.sv
// Host request/response bus of the register access controller.
// master: drives request + response ready; slave: drives ready, response.
interface rggen_register_access_controller_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
);
  logic                      i_request_valid;
  logic                      o_request_ready;
  logic                      i_request_write;
  logic [ADDRESS_WIDTH-1:0]  i_request_address;
  logic [DATA_WIDTH-1:0]     i_request_data;
  logic [DATA_WIDTH/8-1:0]   i_request_strobe;
  logic                      o_response_valid;
  logic                      i_response_ready;
  logic                      o_response_status;
  logic [DATA_WIDTH-1:0]     o_response_data;

  modport master (
    output i_request_valid,
    input  o_request_ready,
    output i_request_write,
    output i_request_address,
    output i_request_data,
    output i_request_strobe,
    input  o_response_valid,
    output i_response_ready,
    input  o_response_status,
    input  o_response_data
  );

  modport slave (
    input  i_request_valid,
    output o_request_ready,
    input  i_request_write,
    input  i_request_address,
    input  i_request_data,
    input  i_request_strobe,
    output o_response_valid,
    input  i_response_ready,
    output o_response_status,
    output o_response_data
  );
endinterface

// File: rtl/rggen_register_access_controller.sv
// Sequences one host access onto a register bank: IDLE -> ACCESS -> RESPONSE.
// Ports: clk, rst_n, host (slave bus), access pulses, write data/mask, read data.
module rggen_register_access_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int REGISTERS     = 4,
  parameter int BASE_ADDRESS  = 0,
  parameter bit ERROR_ON_MISS = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  rggen_register_access_controller_if.slave host,
  output logic [REGISTERS-1:0]            o_read_access,
  output logic [REGISTERS-1:0]            o_write_access,
  output logic [DATA_WIDTH-1:0]           o_write_data,
  output logic [DATA_WIDTH-1:0]           o_write_mask,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);
  localparam int AW  = ADDRESS_WIDTH;
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                  state;
  logic [AW:0]             offset;
  logic [AW:0]             index;
  logic                    hit;
  logic [REGISTERS-1:0]    select;
  logic [DATA_WIDTH-1:0]   mask;
  logic [DATA_WIDTH-1:0]   read_data;

  // Extra top bit: addresses below the base borrow into it and miss.
  assign offset = {1'b0, host.i_request_address}
                - {1'b0, AW'(BASE_ADDRESS)};
  assign index  = offset >> LSB;
  assign hit    = !offset[AW] && (index < (AW+1)'(REGISTERS));
  assign select = hit ? (REGISTERS'(1) << index) : '0;

  always_comb begin
    mask = '0;
    for (int i = 0; i < SW; i++) begin
      mask[8*i+:8] = {8{host.i_request_strobe[i]}};
    end
  end

  // Read pulse is one-hot on a read hit, so an OR-mux suffices.
  always_comb begin
    read_data = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (o_read_access[k]) begin
        read_data = read_data | i_read_data[k*DATA_WIDTH+:DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      host.o_request_ready   <= 1'b1;
      host.o_response_valid  <= 1'b0;
      host.o_response_status <= 1'b0;
      host.o_response_data   <= '0;
      o_read_access          <= '0;
      o_write_access         <= '0;
      o_write_data           <= '0;
      o_write_mask           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (host.i_request_valid) begin
            state                <= ACCESS;
            host.o_request_ready <= 1'b0;
            o_write_data         <= host.i_request_data;
            if (host.i_request_write) begin
              o_write_access <= select;
              o_write_mask   <= mask;
            end else begin
              o_read_access  <= select;
            end
          end
        end
        ACCESS: begin
          state                  <= RESPONSE;
          o_read_access          <= '0;
          o_write_access         <= '0;
          o_write_data           <= '0;
          o_write_mask           <= '0;
          host.o_response_valid  <= 1'b1;
          host.o_response_data   <= read_data;
          host.o_response_status <=
            ERROR_ON_MISS & ~|(o_read_access | o_write_access);
        end
        RESPONSE: begin
          if (host.i_response_ready) begin
            state                  <= IDLE;
            host.o_request_ready   <= 1'b1;
            host.o_response_valid  <= 1'b0;
            host.o_response_status <= 1'b0;
            host.o_response_data   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Directed bench for rggen_register_access_controller (base 0x100, 4 regs).
// dut0 errors on miss, dut1 does not; both see identical stimulus.
module tb_rggen_register_access_controller;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int R  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_register_access_controller_if #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
  ) bus0 ();
  rggen_register_access_controller_if #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
  ) bus1 ();

  logic [R-1:0]    ra0, wa0, ra1, wa1;
  logic [DW-1:0]   wd0, wm0, wd1, wm1;
  logic [R*DW-1:0] rd;

  assign bus1.i_request_valid   = bus0.i_request_valid;
  assign bus1.i_request_write   = bus0.i_request_write;
  assign bus1.i_request_address = bus0.i_request_address;
  assign bus1.i_request_data    = bus0.i_request_data;
  assign bus1.i_request_strobe  = bus0.i_request_strobe;
  assign bus1.i_response_ready  = bus0.i_response_ready;

  rggen_register_access_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTERS(R),
    .BASE_ADDRESS('h100), .ERROR_ON_MISS(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .host(bus0),
    .o_read_access(ra0), .o_write_access(wa0),
    .o_write_data(wd0), .o_write_mask(wm0),
    .i_read_data(rd)
  );

  rggen_register_access_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTERS(R),
    .BASE_ADDRESS('h100), .ERROR_ON_MISS(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .host(bus1),
    .o_read_access(ra1), .o_write_access(wa1),
    .o_write_data(wd1), .o_write_mask(wm1),
    .i_read_data(rd)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a falling edge in IDLE; returns at a falling edge in IDLE.
  task automatic access(string tag, bit w, logic [15:0] a,
                        logic [31:0] d, logic [3:0] s,
                        logic [3:0] ewa, logic [3:0] era,
                        logic [31:0] emask, bit est,
                        logic [31:0] edata);
    bus0.i_request_valid   = 1'b1;
    bus0.i_request_write   = w;
    bus0.i_request_address = a;
    bus0.i_request_data    = d;
    bus0.i_request_strobe  = s;
    bus0.i_response_ready  = 1'b1;
    step();
    bus0.i_request_valid = 1'b0;
    chk({tag, ".wa"}, wa0, ewa);
    chk({tag, ".ra"}, ra0, era);
    chk({tag, ".wd"}, wd0, d);
    chk({tag, ".wm"}, wm0, emask);
    chk({tag, ".rdy"}, bus0.o_request_ready, 0);
    chk({tag, ".wa1"}, wa1 | ra1, ewa | era);
    step();
    chk({tag, ".vld"}, bus0.o_response_valid, 1);
    chk({tag, ".st"}, bus0.o_response_status, est);
    chk({tag, ".dat"}, bus0.o_response_data, edata);
    chk({tag, ".nopulse"}, {wa0, ra0, wm0, wd0}, 0);
    chk({tag, ".st1"}, bus1.o_response_status, 0);
    step();
    chk({tag, ".done"}, bus0.o_response_valid, 0);
    chk({tag, ".rdy2"}, bus0.o_request_ready, 1);
  endtask

  initial begin
    bus0.i_request_valid   = 1'b0;
    bus0.i_request_write   = 1'b0;
    bus0.i_request_address = '0;
    bus0.i_request_data    = '0;
    bus0.i_request_strobe  = '0;
    bus0.i_response_ready  = 1'b0;
    rd = {32'h33333333, 32'h12345678, 32'h11111111, 32'hA0A0A0A0};

    repeat (2) step();
    chk("rst.rdy", bus0.o_request_ready, 1);
    chk("rst.vld", bus0.o_response_valid, 0);
    chk("rst.st", bus0.o_response_status, 0);
    chk("rst.dat", bus0.o_response_data, 0);
    chk("rst.pulse", {wa0, ra0}, 0);
    chk("rst.wdwm", {wd0, wm0}, 0);
    rst_n = 1'b1;
    step();

    access("wr104", 1, 'h104, 'hDEADBEEF, 4'b0011,
           4'b0010, 4'b0000, 'h0000FFFF, 0, 0);
    access("rd10b", 0, 'h10B, 'hCAFE0000, 4'b1111,
           4'b0000, 4'b0100, 0, 0, 'h12345678);
    access("rd100", 0, 'h100, 0, 0,
           4'b0000, 4'b0001, 0, 0, 'hA0A0A0A0);
    access("rd10c", 0, 'h10C, 0, 0,
           4'b0000, 4'b1000, 0, 0, 'h33333333);
    access("rd110", 0, 'h110, 0, 0, 0, 0, 0, 1, 0);
    access("rd0fc", 0, 'h0FC, 0, 0, 0, 0, 0, 1, 0);
    access("rdfffc", 0, 'hFFFC, 0, 0, 0, 0, 0, 1, 0);
    access("wr108s0", 1, 'h108, 'h55AA55AA, 4'b0000,
           4'b0100, 0, 0, 0, 0);
    access("wr10cs9", 1, 'h10D, 'h01234567, 4'b1001,
           4'b1000, 0, 'hFF0000FF, 0, 0);
    access("wrmiss", 1, 'h114, 'h0BADF00D, 4'b1111,
           0, 0, 'hFFFFFFFF, 1, 0);

    // Response back-pressure with a pending request held on the bus.
    bus0.i_response_ready  = 1'b0;
    bus0.i_request_valid   = 1'b1;
    bus0.i_request_write   = 1'b0;
    bus0.i_request_address = 'h104;
    step();
    chk("hold.ra", ra0, 4'b0010);
    bus0.i_request_write   = 1'b1;
    bus0.i_request_address = 'h108;
    bus0.i_request_data    = 'hA5A5A5A5;
    bus0.i_request_strobe  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.vld", bus0.o_response_valid, 1);
      chk("hold.st", bus0.o_response_status, 0);
      chk("hold.dat", bus0.o_response_data, 'h11111111);
      chk("hold.rdy", bus0.o_request_ready, 0);
      chk("hold.wa", wa0, 0);
    end
    bus0.i_response_ready = 1'b1;
    step();
    chk("hold.hs.vld", bus0.o_response_valid, 0);
    chk("hold.hs.rdy", bus0.o_request_ready, 1);
    chk("hold.hs.wa", wa0, 0);
    step();
    bus0.i_request_valid = 1'b0;
    chk("hold.nx.wa", wa0, 4'b0100);
    chk("hold.nx.wm", wm0, 'hFFFFFFFF);
    chk("hold.nx.wd", wd0, 'hA5A5A5A5);
    step();
    chk("hold.nx.vld", bus0.o_response_valid, 1);
    step();
    chk("hold.nx.rdy", bus0.o_request_ready, 1);

    // Asynchronous reset in the middle of ACCESS.
    bus0.i_request_valid   = 1'b1;
    bus0.i_request_write   = 1'b1;
    bus0.i_request_address = 'h104;
    bus0.i_request_data    = 'h00000001;
    bus0.i_request_strobe  = 4'b1111;
    step();
    bus0.i_request_valid = 1'b0;
    chk("arst.pre.wa", wa0, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("arst.wa", wa0, 0);
    chk("arst.wdwm", {wd0, wm0}, 0);
    chk("arst.rdy", bus0.o_request_ready, 1);
    chk("arst.vld", bus0.o_response_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("arst.post.rdy", bus0.o_request_ready, 1);
    chk("arst.post.vld", bus0.o_response_valid, 0);
    chk("arst.post.pulse", {wa0, ra0}, 0);

    // Back-to-back reads with valid held high: one every 3 cycles.
    bus0.i_request_valid = 1'b1;
    bus0.i_request_write = 1'b0;
    for (int i = 0; i < R; i++) begin
      logic [3:0] oh;
      oh = 4'(1 << i);
      bus0.i_request_address = 16'('h100 + 4 * i);
      chk("b2b.rdy", bus0.o_request_ready, 1);
      step();
      chk("b2b.ra", ra0, oh);
      chk("b2b.busy", bus0.o_request_ready, 0);
      step();
      chk("b2b.dat", bus0.o_response_data, rd[i*DW+:DW]);
      chk("b2b.off", ra0, 0);
      step();
    end
    bus0.i_request_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
